// File: rtl/data_mem_responder.sv
// Data-side memory responder for the cpu RAM port.
// Serves LDR reads combinationally and STR writes on the clock edge. The top
// 16 words of the address space are memory-mapped I/O: a byte TX FIFO with a
// valid/ready drain, a status word and (optionally) a free-running 16-bit timer.
//
// Optional feature macro: DMEM_TIMER_EN
//   defined   : timer, snapshot and TIMER_LO/TIMER_HI decode are built
//   undefined : no timer logic; offsets +2/+3 read 0 and ignore writes
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_ram_en/we/re      access enable, write strobe, read strobe
//   i_ram_addr          word address
//   i_ram_data          write data
//   o_ram_data          read data, combinational (0 unless en&re)
//   o_tx_data           FIFO head byte (0 when empty)
//   o_tx_valid          FIFO not empty
//   i_tx_ready          consumer accepts head when high with o_tx_valid
//   o_overflow          sticky: push attempted while FIFO full
module data_mem_responder #(
    parameter int unsigned g_RAM_WIDTH  = 9,
    parameter int unsigned g_RAM_ADDR   = 11,
    parameter int unsigned g_IO_BASE    = 11'h7F0,
    parameter int unsigned g_FIFO_DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_ram_en,
    input  logic                   i_ram_we,
    input  logic                   i_ram_re,
    input  logic [g_RAM_ADDR-1:0]  i_ram_addr,
    input  logic [g_RAM_WIDTH-1:0] i_ram_data,
    output logic [g_RAM_WIDTH-1:0] o_ram_data,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_overflow
);
    localparam int unsigned RAM_DEPTH = 2 ** g_RAM_ADDR;
    localparam int unsigned PTR_W     = $clog2(g_FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam logic [g_RAM_ADDR-1:0] IO_BASE = g_RAM_ADDR'(g_IO_BASE);

    // Address decode
    logic [g_RAM_ADDR-1:0] io_off_full;
    logic [3:0]            io_off;
    logic                  ram_sel;
    logic                  io_sel;
    logic                  wr_c;
    logic                  rd_c;

    assign io_off_full = i_ram_addr - IO_BASE;
    assign io_off      = io_off_full[3:0];
    assign ram_sel     = (i_ram_addr < IO_BASE);
    assign io_sel      = !ram_sel && (io_off_full < g_RAM_ADDR'(16));
    assign wr_c        = i_ram_en & i_ram_we;
    assign rd_c        = i_ram_en & i_ram_re;

    logic push_req;
    logic status_wr;
    assign push_req  = wr_c && io_sel && (io_off == 4'd0);
    assign status_wr = wr_c && io_sel && (io_off == 4'd1);

    // RAM array, deliberately not reset
    logic [g_RAM_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (wr_c && ram_sel) begin
            mem[i_ram_addr] <= i_ram_data;
        end
    end

    // TX FIFO state
    logic [7:0]       fifo_mem [g_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push_ok;
    logic             ovf_nxt;
    logic [7:0]       head_nxt;

    assign fifo_full  = (count == CNT_W'(g_FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign pop        = o_tx_valid & i_tx_ready;
    // A push into a full FIFO still lands when the head leaves in the same cycle
    assign push_ok    = push_req && (!fifo_full || pop);

    // FIFO next-state, overflow flag and registered head
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        ovf_nxt    = o_overflow;
        head_nxt   = '0;

        if (pop) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end
        if (push_ok) begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase

        // Set after clear so a coincident new overflow wins
        if (status_wr) begin
            ovf_nxt = 1'b0;
        end
        if (push_req && fifo_full && !pop) begin
            ovf_nxt = 1'b1;
        end

        // Next head is the byte being pushed when it lands in the head slot
        if (count_nxt != '0) begin
            if (push_ok && (rd_ptr_nxt == wr_ptr)) begin
                head_nxt = i_ram_data[7:0];
            end else begin
                head_nxt = fifo_mem[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= i_ram_data[7:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_nxt;
            o_overflow <= ovf_nxt;
            o_tx_valid <= (count_nxt != '0);
            o_tx_data  <= head_nxt;
        end
    end

`ifdef DMEM_TIMER_EN
    // Free-running timer; reading TIMER_LO captures the high byte for TIMER_HI
    logic [15:0] timer;
    logic [7:0]  snapshot;
    logic        tlo_wr;
    logic        tlo_rd;

    assign tlo_wr = wr_c && io_sel && (io_off == 4'd2);
    assign tlo_rd = rd_c && io_sel && (io_off == 4'd2);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timer    <= '0;
            snapshot <= '0;
        end else begin
            if (tlo_wr) begin
                timer <= '0;
            end else begin
                timer <= timer + 16'd1;
            end
            if (tlo_rd) begin
                snapshot <= timer[15:8];
            end
        end
    end
`endif

    // Combinational read mux
    logic [8:0] status_word;
    assign status_word = {o_overflow, fifo_full, fifo_empty, 6'(count)};

    always_comb begin
        o_ram_data = '0;
        if (rd_c) begin
            if (ram_sel) begin
                o_ram_data = mem[i_ram_addr];
            end else if (io_sel) begin
                case (io_off)
                    4'd1:    o_ram_data = g_RAM_WIDTH'(status_word);
`ifdef DMEM_TIMER_EN
                    4'd2:    o_ram_data = g_RAM_WIDTH'({1'b0, timer[7:0]});
                    4'd3:    o_ram_data = g_RAM_WIDTH'({1'b0, snapshot});
`endif
                    default: o_ram_data = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios plus a randomized
// phase, all checked against a queue/array reference model.
module tb_data_mem_responder;
    localparam int unsigned W     = 9;
    localparam int unsigned A     = 11;
    localparam int unsigned BASE  = 11'h7F0;
    localparam int unsigned DEPTH = 8;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_ram_en, i_ram_we, i_ram_re;
    logic [A-1:0] i_ram_addr;
    logic [W-1:0] i_ram_data;
    logic [W-1:0] o_ram_data;
    logic [7:0]   o_tx_data;
    logic         o_tx_valid;
    logic         i_tx_ready;
    logic         o_overflow;

    always #5 i_clk = ~i_clk;

    data_mem_responder #(
        .g_RAM_WIDTH (W),
        .g_RAM_ADDR  (A),
        .g_IO_BASE   (BASE),
        .g_FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ram_en   (i_ram_en),
        .i_ram_we   (i_ram_we),
        .i_ram_re   (i_ram_re),
        .i_ram_addr (i_ram_addr),
        .i_ram_data (i_ram_data),
        .o_ram_data (o_ram_data),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_overflow (o_overflow)
    );

    int tests = 0;
    int fails = 0;

    // Reference model
    logic [W-1:0] m_ram [int];
    logic [7:0]   m_q [$];
    bit           m_ovf;
    int unsigned  m_timer;
    logic [7:0]   m_snap;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_read(input logic [A-1:0] a);
        int  off;
        bit  full_b, empty_b;
        logic [5:0] cnt;
        if (int'(a) < int'(BASE)) begin
            return m_ram.exists(int'(a)) ? m_ram[int'(a)] : '0;
        end
        off     = int'(a) - int'(BASE);
        full_b  = (m_q.size() == DEPTH);
        empty_b = (m_q.size() == 0);
        cnt     = 6'(m_q.size());
        case (off)
            1: return {m_ovf, full_b, empty_b, cnt};
`ifdef DMEM_TIMER_EN
            2: return {1'b0, m_timer[7:0]};
            3: return {1'b0, m_snap};
`endif
            default: return '0;
        endcase
    endfunction

    // One clock cycle, entered and left at a negedge
    task automatic cyc(input bit en, input bit we, input bit re, input logic [A-1:0] addr,
                       input logic [W-1:0] data, input bit rdy, input string tag);
        bit          pop, full, io;
        int          off;
        logic [7:0]  hi;
        logic [7:0]  head;
        i_ram_en   = en;
        i_ram_we   = we;
        i_ram_re   = re;
        i_ram_addr = addr;
        i_ram_data = data;
        i_tx_ready = rdy;
        #1;
        head = (m_q.size() > 0) ? m_q[0] : 8'h00;
        check({tag, "_valid"}, 16'(o_tx_valid), 16'(m_q.size() > 0));
        check({tag, "_txdata"}, 16'(o_tx_data), 16'(head));
        check({tag, "_ovf"}, 16'(o_overflow), 16'(m_ovf));
        check({tag, "_rd"}, 16'(o_ram_data), (en && re) ? 16'(exp_read(addr)) : 16'h0000);
        @(posedge i_clk);
        pop  = (m_q.size() > 0) && rdy;
        full = (m_q.size() == DEPTH);
        io   = (int'(addr) >= int'(BASE));
        off  = int'(addr) - int'(BASE);
        hi   = m_timer[15:8];
        if (pop) void'(m_q.pop_front());
        if (en && we) begin
            if (!io) m_ram[int'(addr)] = data;
            else if (off == 0) begin
                if (full && !pop) m_ovf = 1'b1;
                else m_q.push_back(data[7:0]);
            end else if (off == 1) m_ovf = 1'b0;
        end
        if (en && we && io && off == 2) m_timer = 0;
        else m_timer = (m_timer + 1) & 32'hFFFF;
        if (en && re && io && off == 2) m_snap = hi;
        @(negedge i_clk);
    endtask

    task automatic idle(input bit rdy, input string tag);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, rdy, tag);
    endtask

    task automatic wr(input logic [A-1:0] addr, input logic [W-1:0] data, input bit rdy, input string tag);
        cyc(1'b1, 1'b1, 1'b0, addr, data, rdy, tag);
    endtask

    task automatic rd(input logic [A-1:0] addr, input bit rdy, input string tag);
        cyc(1'b1, 1'b0, 1'b1, addr, '0, rdy, tag);
    endtask

    // Asynchronous reset asserted mid-cycle; released at a negedge
    task automatic do_reset(input string tag);
        #2 i_rst = 1'b1;
        #1;
        check({tag, "_valid"}, 16'(o_tx_valid), 16'h0000);
        check({tag, "_txdata"}, 16'(o_tx_data), 16'h0000);
        check({tag, "_ovf"}, 16'(o_overflow), 16'h0000);
        m_q.delete();
        m_ovf   = 1'b0;
        m_timer = 0;
        m_snap  = '0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    localparam logic [A-1:0] TX   = A'(BASE);
    localparam logic [A-1:0] STAT = A'(BASE + 1);
    localparam logic [A-1:0] TLO  = A'(BASE + 2);
    localparam logic [A-1:0] THI  = A'(BASE + 3);

    initial begin
        int guard;
        i_rst = 1'b1;
        i_ram_en = 1'b0; i_ram_we = 1'b0; i_ram_re = 1'b0;
        i_ram_addr = '0; i_ram_data = '0; i_tx_ready = 1'b0;
        m_ovf = 1'b0; m_timer = 0; m_snap = '0;

        // Reset state
        repeat (2) @(negedge i_clk);
        check("rst_valid", 16'(o_tx_valid), 16'h0000);
        check("rst_txdata", 16'(o_tx_data), 16'h0000);
        check("rst_ovf", 16'(o_overflow), 16'h0000);
        i_rst = 1'b0;

        // Timer after 300 cycles, snapshot, zeroing write
        guard = 0;
        while (m_timer != 300 && guard < 1000) begin
            idle(1'b0, "tmr_wait");
            guard++;
        end
        check("tmr_reached", 16'(m_timer), 16'd300);
        rd(TLO, 1'b0, "tmr_lo");
        rd(THI, 1'b0, "tmr_hi");
        wr(TLO, 9'h000, 1'b0, "tmr_zero");
        idle(1'b0, "tmr_idle");
        rd(TLO, 1'b0, "tmr_lo_after");
        rd(THI, 1'b0, "tmr_hi_wr_ignored");
        wr(THI, 9'h1FF, 1'b0, "tmr_hi_wr");
        rd(THI, 1'b0, "tmr_hi_after");

        // RAM write/read, neighbour untouched
        wr(11'h013, 9'h0C3, 1'b0, "ram_w13");
        wr(11'h012, 9'h1A5, 1'b0, "ram_w12");
        rd(11'h012, 1'b0, "ram_r12");
        rd(11'h013, 1'b0, "ram_r13");
        cyc(1'b1, 1'b1, 1'b1, 11'h012, 9'h055, 1'b0, "ram_wr_rd_same");
        rd(11'h012, 1'b0, "ram_r12_new");
        wr(11'h012, 9'h1A5, 1'b0, "ram_w12_restore");
        rd(A'(BASE + 7), 1'b0, "io_unused_rd");

        // Fill FIFO, overflow, clear
        for (int i = 1; i <= 8; i++) wr(TX, 9'(i), 1'b0, "fill");
        rd(STAT, 1'b0, "stat_full");
        wr(TX, 9'h0EE, 1'b0, "push_full_drop");
        rd(STAT, 1'b0, "stat_ovf");
        wr(STAT, 9'h000, 1'b0, "stat_clear");
        rd(STAT, 1'b0, "stat_cleared");

        // Full FIFO with simultaneous push and pop, then drain
        wr(TX, 9'h055, 1'b1, "push_pop_full");
        rd(STAT, 1'b0, "stat_still_full");
        for (int i = 0; i < 8; i++) idle(1'b1, "drain");
        rd(STAT, 1'b0, "stat_empty");

        // Held head while not ready
        wr(TX, 9'h0AA, 1'b0, "push_aa");
        for (int i = 0; i < 5; i++) idle(1'b0, "hold_aa");
        idle(1'b1, "pop_aa");
        idle(1'b0, "after_pop");

        // Push into empty FIFO with ready high: no pop in that cycle
        wr(TX, 9'h077, 1'b1, "push_empty_rdy");
        idle(1'b0, "after_push77");
        idle(1'b1, "pop77");

        // Randomized traffic
        for (int i = 0; i < 16; i++) wr(A'(11'h100 + i), 9'($urandom), 1'b0, "rnd_prefill");
        for (int i = 0; i < 400; i++) begin
            int sel;
            logic [A-1:0] a;
            sel = int'($urandom_range(0, 3));
            if (sel < 2) a = A'(11'h100 + $urandom_range(0, 15));
            else if (sel == 2) a = TX;
            else a = A'(BASE + $urandom_range(1, 15));
            cyc(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), a,
                9'($urandom), 1'($urandom), "rnd");
        end

        // Reset with bytes queued; RAM survives
        guard = 0;
        while (m_q.size() > 0 && guard < 20) begin
            idle(1'b1, "pre_rst_drain");
            guard++;
        end
        wr(STAT, 9'h000, 1'b0, "pre_rst_clear");
        for (int i = 0; i < 3; i++) wr(TX, 9'(8'h30 + i), 1'b0, "pre_rst_push");
        idle(1'b0, "pre_rst_idle");
        do_reset("mid_rst");
        rd(11'h012, 1'b0, "ram_after_rst");
        rd(STAT, 1'b0, "stat_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
